// File: rtl/bank_cfg_seq_pkg.sv
// Shared constants and types for the mapper bank configuration sequencer.
// Addresses, unlock signature, FSM state and error-cause encodings.
package bank_cfg_seq_pkg;

  localparam logic [7:0]  ADDR_ACK   = 8'h5A;
  localparam logic [7:0]  ADDR_NAK   = 8'hA5;
  localparam logic [7:0]  ADDR_NIH   = 8'hFF;
  localparam logic [7:0]  ADDR_LAO   = 8'hC0;
  localparam logic [17:0] UNLOCK_SIG = 18'h05140;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MRST,
    ST_UNLK_ACK,
    ST_UNLK_NAK,
    ST_SO_CAP,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_RD_SETUP,
    ST_RD_SAMPLE,
    ST_FIN,
    ST_FAIL
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_SIG      = 2'd1,
    ERR_READBACK = 2'd2
  } err_code_e;

endpackage

// File: rtl/bank_cfg_seq_so_capture.sv
// Captures the mapper's unlock acknowledge bitstream LSB first and flags
// completion together with a signature match on the final bit.
module bank_cfg_seq_so_capture
  import bank_cfg_seq_pkg::*;
#(
  parameter int SO_LEN = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic en_i,
  input  logic so_i,
  output logic done_o,
  output logic match_o
);

  localparam logic [SO_LEN-1:0] SIG = SO_LEN'(UNLOCK_SIG);

  // Only the oldest SO_LEN-1 bits are stored; the newest comes straight from so_i.
  logic [SO_LEN-2:0] shreg_q;
  logic [SO_LEN-1:0] word_d;
  logic [7:0]        cnt_q;

  assign word_d  = {so_i, shreg_q};
  assign done_o  = en_i && (cnt_q == 8'(SO_LEN - 1));
  assign match_o = (word_d == SIG);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (en_i) begin
      shreg_q <= word_d[SO_LEN-1:1];
      cnt_q   <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/bank_cfg_seq.sv
// Mapper bank configuration sequencer: reset, unlock handshake, four bank
// writes with optional readback. All mapper-facing outputs are registered.
module bank_cfg_seq
  import bank_cfg_seq_pkg::*;
#(
  parameter bit VERIFY = 1'b1,
  parameter int SO_LEN = 18
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] CFG_LAO,
  input  logic [7:0] CFG_RAMB,
  input  logic [7:0] CFG_ROMB0,
  input  logic [7:0] CFG_ROMB1,
  output logic       MAP_RSTN,
  output logic       CEN,
  output logic       WEN,
  output logic       OEN,
  output logic       SSN,
  output logic [7:0] ADDR,
  output logic [7:0] DQ_O,
  output logic       DQ_OE,
  input  logic [7:0] DQ_I,
  input  logic       SO_I,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output state_e     dbg_state_o
);

  state_e    state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       mrst_cnt_q, mrst_cnt_d;
  logic [7:0] cfg_q [4];
  err_code_e  fail_code;
  logic       cap_done, cap_match;
  logic       last_bank;

  assign SSN         = 1'b1;
  assign dbg_state_o = state_q;
  assign last_bank   = (idx_q == 2'd3);

  bank_cfg_seq_so_capture #(.SO_LEN(SO_LEN)) u_so_capture (
    .clk_i   (CLK),
    .rst_i   (RST),
    .start_i (state_q == ST_UNLK_NAK),
    .en_i    (state_q == ST_SO_CAP),
    .so_i    (SO_I),
    .done_o  (cap_done),
    .match_o (cap_match)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mrst_cnt_d = mrst_cnt_q;
    fail_code  = ERR_NONE;
    case (state_q)
      ST_IDLE: if (START) begin
        state_d    = ST_MRST;
        mrst_cnt_d = 1'b0;
      end
      ST_MRST: begin
        mrst_cnt_d = 1'b1;
        if (mrst_cnt_q) state_d = ST_UNLK_ACK;
      end
      ST_UNLK_ACK: state_d = ST_UNLK_NAK;
      ST_UNLK_NAK: state_d = ST_SO_CAP;
      ST_SO_CAP: if (cap_done) begin
        if (cap_match) begin
          state_d = ST_WR_SETUP;
          idx_d   = 2'd0;
        end else begin
          state_d   = ST_FAIL;
          fail_code = ERR_SIG;
        end
      end
      ST_WR_SETUP:  state_d = ST_WR_STROBE;
      ST_WR_STROBE: state_d = ST_WR_HOLD;
      ST_WR_HOLD: begin
        if (VERIFY)         state_d = ST_RD_SETUP;
        else if (last_bank) state_d = ST_FIN;
        else begin
          state_d = ST_WR_SETUP;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_RD_SETUP: state_d = ST_RD_SAMPLE;
      ST_RD_SAMPLE: begin
        if (DQ_I != cfg_q[idx_q]) begin
          state_d   = ST_FAIL;
          fail_code = ERR_READBACK;
        end else if (last_bank) state_d = ST_FIN;
        else begin
          state_d = ST_WR_SETUP;
          idx_d   = idx_q + 2'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      mrst_cnt_q <= 1'b0;
      cfg_q[0]   <= 8'hFF;
      cfg_q[1]   <= 8'hFF;
      cfg_q[2]   <= 8'hFF;
      cfg_q[3]   <= 8'hFF;
      MAP_RSTN   <= 1'b0;
      CEN        <= 1'b1;
      WEN        <= 1'b1;
      OEN        <= 1'b1;
      ADDR       <= ADDR_NIH;
      DQ_O       <= 8'h00;
      DQ_OE      <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mrst_cnt_q <= mrst_cnt_d;
      if (state_q == ST_IDLE && START) begin
        cfg_q[0] <= CFG_LAO;
        cfg_q[1] <= CFG_RAMB;
        cfg_q[2] <= CFG_ROMB0;
        cfg_q[3] <= CFG_ROMB1;
      end
      MAP_RSTN <= (state_d != ST_MRST);
      CEN      <= !(state_d inside {ST_WR_SETUP, ST_WR_STROBE, ST_RD_SETUP, ST_RD_SAMPLE});
      WEN      <= (state_d != ST_WR_SETUP);
      OEN      <= !(state_d inside {ST_RD_SETUP, ST_RD_SAMPLE});
      DQ_OE    <= (state_d inside {ST_WR_SETUP, ST_WR_STROBE});
      case (state_d)
        ST_UNLK_ACK: ADDR <= ADDR_ACK;
        ST_UNLK_NAK: ADDR <= ADDR_NAK;
        ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD, ST_RD_SETUP, ST_RD_SAMPLE:
          ADDR <= ADDR_LAO + {6'd0, idx_d};
        default:     ADDR <= ADDR_NIH;
      endcase
      DQ_O <= (state_d inside {ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD, ST_RD_SETUP, ST_RD_SAMPLE})
              ? cfg_q[idx_d] : 8'h00;
      BUSY <= !(state_d inside {ST_IDLE, ST_FIN});
      DONE <= (state_d == ST_FIN);
      if (state_q == ST_IDLE && state_d == ST_MRST) begin
        ERR      <= 1'b0;
        ERR_CODE <= ERR_NONE;
      end else if (state_d == ST_FAIL) begin
        ERR      <= 1'b1;
        ERR_CODE <= fail_code;
      end
    end
  end

endmodule

// File: doc/bank_cfg_seq.md
BANK_CFG_SEQ -- requirements
Module: bank_cfg_seq

Interface
REQ-001 Parameter VERIFY, default 1: when 1, each bank write is followed by a readback compare.
REQ-002 Parameter SO_LEN, default 18: length of the unlock acknowledge bitstream, in bits.
REQ-003 CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 RST  in  1  reset; asynchronous, active-high.
REQ-005 START  in  1  one-cycle pulse; begins a sequence; ignored unless the block is in IDLE.
REQ-006 CFG_LAO, CFG_RAMB, CFG_ROMB0, CFG_ROMB1  in  8 each  bank values; captured on the accepted START.
REQ-007 MAP_RSTN, CEN, WEN, OEN, SSN  out  1 each  mapper control strobes, active-low.
REQ-008 ADDR  out  8  mapper address bus.
REQ-009 DQ_O  out  8  write data.
REQ-010 DQ_OE  out  1  DQ_O output enable.
REQ-011 DQ_I  in  8  mapper read data.
REQ-012 SO_I  in  1  mapper synchronous serial output.
REQ-013 BUSY, DONE, ERR  out  1 each  status outputs.
REQ-014 ERR_CODE  out  2  error cause: 0 = none, 1 = bitstream mismatch, 2 = readback mismatch.

Function
REQ-015 States: IDLE, MRST, UNLK_ACK, UNLK_NAK, SO_CAP, WR_SETUP, WR_STROBE, WR_HOLD, RD_SETUP, RD_SAMPLE, FIN, FAIL.
REQ-016 Idle drive: CEN=WEN=OEN=SSN=1, ADDR=8'hFF, DQ_OE=0.
REQ-017 MRST: entered on an accepted START; drives MAP_RSTN=0 for 2 cycles, then goes to UNLK_ACK.
  - ERR, DONE and ERR_CODE clear on entry to MRST.
REQ-018 UNLK_ACK: drives ADDR=8'h5A for 1 cycle; control strobes stay high.
REQ-019 UNLK_NAK: drives ADDR=8'hA5 for 1 cycle, then ADDR returns to 8'hFF.
REQ-020 SO_CAP: samples SO_I on the SO_LEN consecutive edges following the UNLK_NAK edge, LSB first.
  - The captured word is compared with UNLOCK_SIG = 18'h05140.
  - Mismatch -> FAIL with ERR_CODE=1.
REQ-021 Bank writes cover index i = 0..3 in order, at ADDR = 8'hC0+i, with data LAO, RAMB, ROMB0, ROMB1 respectively.
REQ-022 Write cycle:
  - WR_SETUP: CEN=0, WEN=0, DQ_OE=1, ADDR and DQ_O valid.
  - WR_STROBE: WEN=1; this rising edge is the mapper latch edge.
  - WR_HOLD: CEN=1, DQ_OE=0, ADDR and DQ_O still held.
  - Each stage lasts 1 cycle; ADDR and DQ_O are stable across all three.
REQ-023 Readback (VERIFY=1 only), after each WR_HOLD:
  - RD_SETUP: CEN=0, OEN=0, WEN=1, DQ_OE=0.
  - RD_SAMPLE: DQ_I compared with the written byte.
  - Mismatch -> FAIL with ERR_CODE=2.
  - After either case, strobes return high.
REQ-024 With VERIFY=0, WR_HOLD goes directly to the next index, or to FIN after index 3.
REQ-025 FIN pulses DONE for 1 cycle, then the block returns to IDLE.
REQ-026 FAIL holds ERR=1 until the next accepted START; the block returns to IDLE with the idle drive.
REQ-027 BUSY=1 in every state except IDLE and FIN.
REQ-028 DQ_OE and OEN are never both active in the same cycle.
REQ-029 START asserted in the same cycle as the FIN cycle is ignored.
REQ-030 Cycle count from START to DONE:
  - VERIFY=1: 2+1+1+SO_LEN+4*5 = 42 cycles.
  - VERIFY=0: 34 cycles.

Reset
REQ-031 RST asynchronously forces state IDLE, the idle drive, MAP_RSTN=0, BUSY=DONE=ERR=0 and ERR_CODE=0.
  - RST mid-sequence aborts it with no partial strobe.
REQ-032 On RST deassertion, MAP_RSTN goes to 1 on the next edge.
REQ-033 Captured config registers reset to 8'hFF.

Structure
REQ-034 A shared package holds:
  - constants ADDR_ACK=8'h5A, ADDR_NAK=8'hA5, ADDR_NIH=8'hFF, ADDR_LAO=8'hC0 and UNLOCK_SIG;
  - the state enum;
  - the ERR_CODE enum.
REQ-035 One sub-module, so_capture: an SO_LEN-bit shift register and counter with start, done and match outputs.

Verification
REQ-036 START with CFG = 12/34/56/78, VERIFY=1, conforming mapper model -> bank regs read 12,34,56,78; DONE at cycle 42; ERR=0.
REQ-037 Model flips SO bit 6 -> FAIL, ERR=1, ERR_CODE=1; zero WEN falling edges observed.
REQ-038 Model returns 8'h00 on read of 8'hC2 -> ERR_CODE=2 after the third write; no write to 8'hC3.
REQ-039 RST pulsed during WR_SETUP of index 1 -> same cycle: CEN=WEN=1, DQ_OE=0, MAP_RSTN=0, BUSY=0.
REQ-040 START repeated while BUSY, and START in the FIN cycle -> both ignored; exactly one DONE pulse.
REQ-041 VERIFY=0 -> DONE at cycle 34; OEN never asserted.
